mem_arbiter: RTL and testbench

//  Shares the single pmem access path between the instruction fetch unit (IFU, read-only)
//  and the load/store unit (LSU, read/write, 1/2/4-byte).

---
 rtl/mem_arbiter.sv | 169 ++++++++++++++++
 tb/tb_mem_arbiter.sv | 218 +++++++++++++++++++++
 2 files changed

// File: rtl/mem_arbiter.sv
// Round-robin IFU/LSU arbiter onto one pmem path, one transaction in flight; accept->resp_valid >= 3 cycles.
// req_ready only in IDLE; request fields held until mem_req_ready; response held until resp_ready.
module mem_arbiter #(
    parameter int ADDR_W  = 32,
    parameter int DATA_W  = 32,
    parameter int TIMEOUT = 255
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              ifu_req_valid,
    output logic              ifu_req_ready,
    input  logic [ADDR_W-1:0] ifu_addr,
    output logic              ifu_resp_valid,
    output logic [DATA_W-1:0] ifu_resp_data,
    output logic              ifu_resp_err,
    input  logic              ifu_resp_ready,
    input  logic              lsu_req_valid,
    output logic              lsu_req_ready,
    input  logic [ADDR_W-1:0] lsu_addr,
    input  logic              lsu_wen,
    input  logic [DATA_W-1:0] lsu_wdata,
    input  logic [2:0]        lsu_len,
    output logic              lsu_resp_valid,
    output logic [DATA_W-1:0] lsu_resp_data,
    output logic              lsu_resp_err,
    input  logic              lsu_resp_ready,
    output logic              mem_req_valid,
    input  logic              mem_req_ready,
    output logic [ADDR_W-1:0] mem_addr,
    output logic              mem_wen,
    output logic [DATA_W-1:0] mem_wdata,
    output logic [2:0]        mem_len,
    input  logic              mem_resp_valid,
    input  logic [DATA_W-1:0] mem_resp_data
);

    typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} state_t;

    typedef struct packed {
        logic [ADDR_W-1:0] addr;
        logic              wen;
        logic [DATA_W-1:0] wdata;
        logic [2:0]        len;
    } req_t;

    localparam logic        OWN_IFU    = 1'b0;
    localparam logic        OWN_LSU    = 1'b1;
    localparam int          CNT_W      = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
    localparam int unsigned TO_LAST    = (TIMEOUT > 0) ? TIMEOUT - 1 : 0;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TO_LAST);

    state_t            state_q, state_d;
    req_t              req_q, req_d;
    logic              owner_q, owner_d;
    logic              last_grant_q, last_grant_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [DATA_W-1:0] rdata_q, rdata_d;
    logic              rerr_q, rerr_d;
    logic              grant_lsu;
    logic              len_ok;

    // On a tie the requester that was not served last goes first.
    assign grant_lsu = lsu_req_valid && (!ifu_req_valid || last_grant_q == OWN_IFU);
    assign len_ok    = (lsu_len == 3'd1) || (lsu_len == 3'd2) || (lsu_len == 3'd4);

    always_comb begin
        state_d       = state_q;
        req_d         = req_q;
        owner_d       = owner_q;
        last_grant_d  = last_grant_q;
        cnt_d         = cnt_q;
        rdata_d       = rdata_q;
        rerr_d        = rerr_q;
        ifu_req_ready = 1'b0;
        lsu_req_ready = 1'b0;
        case (state_q)
            IDLE: begin
                if (ifu_req_valid || lsu_req_valid) begin
                    ifu_req_ready = !grant_lsu;
                    lsu_req_ready = grant_lsu;
                    owner_d       = grant_lsu ? OWN_LSU : OWN_IFU;
                    if (grant_lsu) begin
                        req_d.addr  = lsu_addr;
                        req_d.wen   = lsu_wen;
                        req_d.wdata = lsu_wdata;
                        req_d.len   = lsu_len;
                    end else begin
                        req_d.addr  = ifu_addr;
                        req_d.wen   = 1'b0;
                        req_d.wdata = '0;
                        req_d.len   = 3'd4;
                    end
                    if (grant_lsu && !len_ok) begin
                        rdata_d = '0;
                        rerr_d  = 1'b1;
                        state_d = RESP;
                    end else begin
                        state_d = ISSUE;
                    end
                end
            end
            ISSUE: begin
                if (mem_req_ready) begin
                    cnt_d   = '0;
                    state_d = WAIT;
                end
            end
            WAIT: begin
                if (cnt_q != '1) begin
                    cnt_d = cnt_q + 1'b1;
                end
                if (mem_resp_valid) begin
                    rdata_d = req_q.wen ? '0 : mem_resp_data;
                    rerr_d  = 1'b0;
                    state_d = RESP;
                end else if (TIMEOUT != 0 && cnt_q == CNT_LAST) begin
                    rdata_d = '0;
                    rerr_d  = 1'b1;
                    state_d = RESP;
                end
            end
            RESP: begin
                if (owner_q == OWN_LSU ? lsu_resp_ready : ifu_resp_ready) begin
                    last_grant_d = owner_q;
                    state_d      = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= IDLE;
            req_q        <= '0;
            owner_q      <= OWN_IFU;
            last_grant_q <= OWN_LSU;
            cnt_q        <= '0;
            rdata_q      <= '0;
            rerr_q       <= 1'b0;
        end else begin
            state_q      <= state_d;
            req_q        <= req_d;
            owner_q      <= owner_d;
            last_grant_q <= last_grant_d;
            cnt_q        <= cnt_d;
            rdata_q      <= rdata_d;
            rerr_q       <= rerr_d;
        end
    end

    logic ifu_act, lsu_act;
    assign ifu_act = (state_q == RESP) && (owner_q == OWN_IFU);
    assign lsu_act = (state_q == RESP) && (owner_q == OWN_LSU);

    assign ifu_resp_valid = ifu_act;
    assign ifu_resp_data  = ifu_act ? rdata_q : '0;
    assign ifu_resp_err   = ifu_act & rerr_q;
    assign lsu_resp_valid = lsu_act;
    assign lsu_resp_data  = lsu_act ? rdata_q : '0;
    assign lsu_resp_err   = lsu_act & rerr_q;

    assign mem_req_valid = (state_q == ISSUE);
    assign mem_addr      = req_q.addr;
    assign mem_wen       = req_q.wen;
    assign mem_wdata     = req_q.wdata;
    assign mem_len       = req_q.len;

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter with TIMEOUT = 8; inputs driven 1 ns after posedge, outputs sampled later in the cycle.
module tb_mem_arbiter;
    localparam int AW = 32;
    localparam int DW = 32;
    localparam int TO = 8;

    logic          clk = 1'b0;
    logic          rst;
    logic          ifu_req_valid, ifu_req_ready;
    logic [AW-1:0] ifu_addr;
    logic          ifu_resp_valid, ifu_resp_err, ifu_resp_ready;
    logic [DW-1:0] ifu_resp_data;
    logic          lsu_req_valid, lsu_req_ready, lsu_wen;
    logic [AW-1:0] lsu_addr;
    logic [DW-1:0] lsu_wdata;
    logic [2:0]    lsu_len;
    logic          lsu_resp_valid, lsu_resp_err, lsu_resp_ready;
    logic [DW-1:0] lsu_resp_data;
    logic          mem_req_valid, mem_req_ready, mem_wen, mem_resp_valid;
    logic [AW-1:0] mem_addr;
    logic [DW-1:0] mem_wdata, mem_resp_data;
    logic [2:0]    mem_len;

    int n_tests = 0;
    int n_fail  = 0;

    mem_arbiter #(.ADDR_W(AW), .DATA_W(DW), .TIMEOUT(TO)) dut (
        .clk(clk), .rst(rst),
        .ifu_req_valid(ifu_req_valid), .ifu_req_ready(ifu_req_ready), .ifu_addr(ifu_addr),
        .ifu_resp_valid(ifu_resp_valid), .ifu_resp_data(ifu_resp_data),
        .ifu_resp_err(ifu_resp_err), .ifu_resp_ready(ifu_resp_ready),
        .lsu_req_valid(lsu_req_valid), .lsu_req_ready(lsu_req_ready), .lsu_addr(lsu_addr),
        .lsu_wen(lsu_wen), .lsu_wdata(lsu_wdata), .lsu_len(lsu_len),
        .lsu_resp_valid(lsu_resp_valid), .lsu_resp_data(lsu_resp_data),
        .lsu_resp_err(lsu_resp_err), .lsu_resp_ready(lsu_resp_ready),
        .mem_req_valid(mem_req_valid), .mem_req_ready(mem_req_ready), .mem_addr(mem_addr),
        .mem_wen(mem_wen), .mem_wdata(mem_wdata), .mem_len(mem_len),
        .mem_resp_valid(mem_resp_valid), .mem_resp_data(mem_resp_data)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        ifu_req_valid  = 1'b0; ifu_addr = '0; ifu_resp_ready = 1'b1;
        lsu_req_valid  = 1'b0; lsu_addr = '0; lsu_wen = 1'b0; lsu_wdata = '0; lsu_len = 3'd4;
        lsu_resp_ready = 1'b1;
        mem_req_ready  = 1'b1; mem_resp_valid = 1'b0; mem_resp_data = '0;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        idle_inputs();
        step();
        step();
        rst = 1'b0;
    endtask

    // One complete transaction with both requesters held valid: check who is granted, then answer it.
    task automatic serve(input bit exp_lsu, input string tag, input logic [DW-1:0] rd);
        #1;
        chk({tag, "_grant"}, {62'd0, ifu_req_ready, lsu_req_ready}, exp_lsu ? 64'd1 : 64'd2);
        step();
        step();
        mem_resp_valid = 1'b1; mem_resp_data = rd;
        step();
        mem_resp_valid = 1'b0;
        chk({tag, "_resp"}, {62'd0, ifu_resp_valid, lsu_resp_valid}, exp_lsu ? 64'd1 : 64'd2);
        chk({tag, "_data"}, exp_lsu ? lsu_resp_data : ifu_resp_data, rd);
        step();
    endtask

    initial begin
        int lat;

        // Reset state
        rst = 1'b1;
        idle_inputs();
        step();
        step();
        chk("rst_req_ready", {ifu_req_ready, lsu_req_ready}, 0);
        chk("rst_valids", {mem_req_valid, ifu_resp_valid, lsu_resp_valid}, 0);
        chk("rst_errs", {ifu_resp_err, lsu_resp_err}, 0);
        chk("rst_data", {ifu_resp_data, lsu_resp_data}, 0);
        chk("rst_mem_addr", mem_addr, 0);
        chk("rst_mem_fields", {mem_wen, mem_len, mem_wdata}, 0);
        rst = 1'b0;
        step();

        // T1: minimum-latency IFU read
        ifu_req_valid = 1'b1; ifu_addr = 32'h8000_0000;
        #1;
        chk("t1_c0_ready", {ifu_req_ready, lsu_req_ready}, 2'b10);
        step();
        ifu_req_valid = 1'b0;
        chk("t1_c1_mem_req", {mem_req_valid, ifu_req_ready}, 2'b10);
        chk("t1_c1_addr", mem_addr, 32'h8000_0000);
        chk("t1_c1_wen_len", {mem_wen, mem_len}, {1'b0, 3'd4});
        step();
        chk("t1_c2_no_resp", ifu_resp_valid, 0);
        mem_resp_valid = 1'b1; mem_resp_data = 32'hDEAD_BEEF;
        step();
        mem_resp_valid = 1'b0;
        chk("t1_c3_valid", {ifu_resp_valid, lsu_resp_valid}, 2'b10);
        chk("t1_c3_data", ifu_resp_data, 32'hDEAD_BEEF);
        chk("t1_c3_err", ifu_resp_err, 0);
        step();
        chk("t1_c4_done", ifu_resp_valid, 0);

        // T2: both requesters valid from reset -> IFU, LSU, IFU, LSU
        do_reset();
        ifu_req_valid = 1'b1; ifu_addr = 32'h8000_0100;
        lsu_req_valid = 1'b1; lsu_addr = 32'h8000_0200; lsu_wen = 1'b0; lsu_len = 3'd4;
        serve(1'b0, "t2_a", 32'h1111_0001);
        serve(1'b1, "t2_b", 32'h2222_0002);
        serve(1'b0, "t2_c", 32'h3333_0003);
        serve(1'b1, "t2_d", 32'h4444_0004);
        idle_inputs();
        step();

        // T3: LSU half-word store with memory stalling the request for 5 cycles
        lsu_req_valid = 1'b1; lsu_addr = 32'h8000_0010; lsu_wen = 1'b1;
        lsu_wdata = 32'h1234_5678; lsu_len = 3'd2; mem_req_ready = 1'b0;
        #1;
        chk("t3_accept", {ifu_req_ready, lsu_req_ready}, 2'b01);
        step();
        lsu_req_valid = 1'b0; lsu_addr = 32'hFFFF_FFFF; lsu_wen = 1'b0;
        lsu_wdata = 32'hAAAA_5555; lsu_len = 3'd1;
        for (int i = 0; i < 5; i++) begin
            chk("t3_stall_addr", {mem_req_valid, mem_addr}, {1'b1, 32'h8000_0010});
            chk("t3_stall_fields", {mem_wen, mem_len, mem_wdata}, {1'b1, 3'd2, 32'h1234_5678});
            step();
        end
        mem_req_ready = 1'b1;
        step();
        mem_resp_valid = 1'b1; mem_resp_data = 32'hFFFF_FFFF;
        lsu_resp_ready = 1'b0;
        step();
        mem_resp_valid = 1'b0;
        chk("t3_resp", {lsu_resp_valid, lsu_resp_err, ifu_resp_valid}, 3'b100);
        chk("t3_data_zero", lsu_resp_data, 0);
        step();
        chk("t3_resp_held", lsu_resp_valid, 1);
        lsu_resp_ready = 1'b1;
        step();
        chk("t3_resp_done", lsu_resp_valid, 0);

        // T4: memory never answers -> error after TIMEOUT cycles in WAIT
        lsu_req_valid = 1'b1; lsu_addr = 32'h8000_0020; lsu_wen = 1'b0; lsu_len = 3'd4;
        step();
        lsu_req_valid = 1'b0;
        chk("t4_issue", mem_req_valid, 1);
        lat = 0;
        for (int i = 0; i < 30; i++) begin
            step();
            lat++;
            if (lsu_resp_valid) break;
        end
        chk("t4_latency", lat, 9);
        chk("t4_err", lsu_resp_err, 1);
        chk("t4_data", lsu_resp_data, 0);
        step();

        // T5: illegal length -> immediate error, no memory access
        lsu_req_valid = 1'b1; lsu_len = 3'd3;
        #1;
        chk("t5_accept", lsu_req_ready, 1);
        step();
        lsu_req_valid = 1'b0; lsu_len = 3'd4;
        chk("t5_no_mem_req", mem_req_valid, 0);
        chk("t5_resp", {lsu_resp_valid, lsu_resp_err}, 2'b11);
        chk("t5_data", lsu_resp_data, 0);
        step();

        // T6: reset while in WAIT, then a stray late response
        ifu_req_valid = 1'b1; ifu_addr = 32'h8000_0040;
        step();
        ifu_req_valid = 1'b0;
        step();
        rst = 1'b1;
        step();
        rst = 1'b0;
        mem_resp_valid = 1'b1; mem_resp_data = 32'h5555_AAAA;
        #1;
        chk("t6_after_rst", {mem_req_valid, ifu_resp_valid, lsu_resp_valid}, 0);
        step();
        mem_resp_valid = 1'b0;
        chk("t6_stray_ignored", {ifu_resp_valid, lsu_resp_valid}, 0);
        step();
        chk("t6_still_idle", {ifu_resp_valid, mem_req_valid}, 0);
        ifu_req_valid = 1'b1; lsu_req_valid = 1'b1;
        #1;
        chk("t6_ifu_wins_after_rst", {ifu_req_ready, lsu_req_ready}, 2'b10);
        step();
        idle_inputs();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
        $fatal(1);
    end
endmodule
